// File: rtl/wrr_arbiter_pkg.sv
// Shared types and constants for the weighted round-robin arbiter.
package wrr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int unsigned DEF_N        = 4;
    localparam int unsigned DEF_WEIGHT_W = 4;
    localparam int unsigned DEF_TIMEOUT  = 16;

    // Index of the set bit in a one-hot vector (up to 16 requesters); 0 when empty.
    function automatic int unsigned oh2idx(input logic [15:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request scanning ptr, ptr+1, ... mod N.
module rr_pick
    import wrr_arbiter_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] pick_o,
    output logic                 any_o
);

    localparam int unsigned IDW = $clog2(N);

    int unsigned idx;

    // Scan from the pointer upward with wrap; the first hit wins.
    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[idx]) begin
                any_o  = 1'b1;
                pick_o = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one-hot grant held for a per-requester credit
// of beats (or until the owner drops its request), then one turnaround cycle.
// Optional grant watchdog enabled by defining WRR_ARBITER_TIMEOUT_EN.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic [N-1:0]          i_req,
    input  logic [N*WEIGHT_W-1:0] i_weight,
    input  logic                  i_beat,
    output logic [N-1:0]          o_gnt,
    output logic                  o_gnt_vld,
    output logic [$clog2(N)-1:0]  o_gnt_id,
    output logic                  o_timeout
);

    localparam int unsigned IDW = $clog2(N);

    state_e              state_q;
    logic [N-1:0]        gnt_q;
    logic                vld_q;
    logic [IDW-1:0]      ptr_q;
    logic [WEIGHT_W-1:0] credit_q;

    logic [IDW-1:0]      pick;
    logic                any;
    logic [IDW-1:0]      owner;
    logic [IDW-1:0]      ptr_nxt;
    logic [WEIGHT_W-1:0] w_pick;
    logic [WEIGHT_W-1:0] credit_load;
    logic                held;
    logic                counted;
    logic                last_beat;
    logic                wd_fire;
    logic                grant_exit;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req_i  (i_req),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .any_o  (any)
    );

    // Owner decoded from the grant flops, so it reads 0 whenever no grant is held.
    assign owner = IDW'(oh2idx(16'(gnt_q)));

    // Weight of the candidate winner; a zero weight still earns one beat.
    always_comb begin
        w_pick = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (pick == IDW'(k)) w_pick = i_weight[k*WEIGHT_W +: WEIGHT_W];
        end
        credit_load = (w_pick == '0) ? WEIGHT_W'(1) : w_pick;
    end

    // Beat qualification and exit conditions; a request drop overrides a same-cycle beat.
    always_comb begin
        held       = i_req[owner];
        counted    = i_beat & held;
        last_beat  = counted && (credit_q == WEIGHT_W'(1));
        ptr_nxt    = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;
        grant_exit = !held || last_beat || wd_fire;
    end

`ifdef WRR_ARBITER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wdog_q;
    logic          tout_q;

    // Fires on the cycle whose increment would make the idle count reach TIMEOUT.
    assign wd_fire   = held && !i_beat && (wdog_q == TW'(TIMEOUT - 1));
    assign o_timeout = tout_q;
`else
    assign wd_fire   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Arbitration FSM with registered grant, pointer, credit and watchdog.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            vld_q    <= 1'b0;
            ptr_q    <= '0;
            credit_q <= '0;
`ifdef WRR_ARBITER_TIMEOUT_EN
            wdog_q   <= '0;
            tout_q   <= 1'b0;
`endif
        end else begin
`ifdef WRR_ARBITER_TIMEOUT_EN
            tout_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (any) begin
                        state_q  <= GRANT;
                        gnt_q    <= N'(1) << pick;
                        vld_q    <= 1'b1;
                        credit_q <= credit_load;
`ifdef WRR_ARBITER_TIMEOUT_EN
                        wdog_q   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (grant_exit) begin
                        state_q  <= IDLE;
                        gnt_q    <= '0;
                        vld_q    <= 1'b0;
                        ptr_q    <= ptr_nxt;
                        credit_q <= '0;
`ifdef WRR_ARBITER_TIMEOUT_EN
                        tout_q   <= wd_fire;
`endif
                    end else begin
                        if (counted) credit_q <= credit_q - 1'b1;
`ifdef WRR_ARBITER_TIMEOUT_EN
                        wdog_q <= counted ? '0 : wdog_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_vld = vld_q;
    assign o_gnt_id  = owner;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus random traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_wrr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int TO = 16;
`ifdef WRR_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        i_nrst;
    logic [3:0]  i_req;
    logic [15:0] i_weight;
    logic        i_beat;
    logic [3:0]  o_gnt;
    logic        o_gnt_vld;
    logic [1:0]  o_gnt_id;
    logic        o_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: owner index (-1 = nobody), remaining beats, next start, idle cycles.
    int m_own  = -1;
    int m_cred = 0;
    int m_ptr  = 0;
    int m_wd   = 0;
    bit m_tout = 0;

    wrr_arbiter #(
        .N        (N),
        .WEIGHT_W (WW),
        .TIMEOUT  (TO)
    ) dut (
        .i_clk     (clk),
        .i_nrst    (i_nrst),
        .i_req     (i_req),
        .i_weight  (i_weight),
        .i_beat    (i_beat),
        .o_gnt     (o_gnt),
        .o_gnt_vld (o_gnt_vld),
        .o_gnt_id  (o_gnt_id),
        .o_timeout (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_cred = 0;
        m_ptr  = 0;
        m_wd   = 0;
        m_tout = 0;
    endtask

    // One clock edge of the arbitration rules, using the inputs present at the edge.
    task automatic model_step();
        int k;
        m_tout = 0;
        if (!i_nrst) begin
            model_reset();
        end else if (m_own < 0) begin
            if (i_req != 4'b0) begin
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (m_own < 0 && i_req[k]) m_own = k;
                end
                m_cred = int'(i_weight[m_own*WW +: WW]);
                if (m_cred == 0) m_cred = 1;
                m_wd = 0;
            end
        end else if (!i_req[m_own]) begin
            m_ptr = (m_own + 1) % N;
            m_own = -1;
        end else if (i_beat) begin
            m_cred = m_cred - 1;
            m_wd   = 0;
            if (m_cred == 0) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end
        end else begin
            m_wd = m_wd + 1;
            if (TO_EN && m_wd == TO) begin
                m_ptr  = (m_own + 1) % N;
                m_own  = -1;
                m_tout = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        i_nrst = 1'b0;
        i_req  = 4'b0;
        i_beat = 1'b0;
        tick();
        tick();
        i_nrst = 1'b1;
    endtask

    task automatic test_reset();
        i_nrst   = 1'b0;
        i_req    = 4'b1111;
        i_weight = 16'h1111;
        i_beat   = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (o_gnt !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_gnt: got %b want 0000", o_gnt);
        end
        n_cmp++;
        if (o_gnt_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vld: got %b want 0", o_gnt_vld);
        end
        n_cmp++;
        if (o_gnt_id !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_id: got %0d want 0", o_gnt_id);
        end
        n_cmp++;
        if (o_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_timeout: got %b want 0", o_timeout);
        end
        i_nrst = 1'b1;
        tick();
        n_cmp++;
        if (o_gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_first_grant: got %b want 0001", o_gnt);
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_g [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
        do_reset();
        i_weight = 16'h0300;
        i_req    = 4'b0100;
        i_beat   = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            n_cmp++;
            if (o_gnt !== exp_g[t]) begin
                n_bad++;
                $display("FAIL single_gnt[%0d]: got %b want %b", t, o_gnt, exp_g[t]);
            end
            n_cmp++;
            if (o_gnt_vld !== (exp_g[t] != 4'b0)) begin
                n_bad++;
                $display("FAIL single_vld[%0d]: got %b want %b", t, o_gnt_vld, exp_g[t] != 4'b0);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        i_weight = 16'h1111;
        i_req    = 4'b1111;
        i_beat   = 1'b1;
        for (int t = 0; t < 9; t++) begin
            tick();
            n_cmp++;
            if (o_gnt !== exp_g[t]) begin
                n_bad++;
                $display("FAIL rotation_gnt[%0d]: got %b want %b", t, o_gnt, exp_g[t]);
            end
            n_cmp++;
            if (o_gnt_id !== 2'(idx_of(exp_g[t]))) begin
                n_bad++;
                $display("FAIL rotation_id[%0d]: got %0d want %0d", t, o_gnt_id, idx_of(exp_g[t]));
            end
        end
    endtask

    task automatic test_weighted_drop();
        logic [3:0] exp_g [14] = '{4'b0001, 4'b0000,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                   4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b1000,
                                   4'b0000, 4'b0001};
        do_reset();
        i_weight = 16'h2051;
        i_beat   = 1'b1;
        for (int t = 0; t < 14; t++) begin
            i_req = (t >= 12) ? 4'b0111 : 4'b1111;
            tick();
            n_cmp++;
            if (o_gnt !== exp_g[t]) begin
                n_bad++;
                $display("FAIL weighted_gnt[%0d]: got %b want %b", t, o_gnt, exp_g[t]);
            end
            n_cmp++;
            if (o_gnt_id !== 2'(idx_of(exp_g[t]))) begin
                n_bad++;
                $display("FAIL weighted_id[%0d]: got %0d want %0d", t, o_gnt_id, idx_of(exp_g[t]));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_weight = 16'h2051;
        i_req    = 4'b0010;
        i_beat   = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (o_gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL midreset_pre: got %b want 0010", o_gnt);
        end
        #2;
        i_nrst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (o_gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL midreset_async: got %b want 0000", o_gnt);
        end
        n_cmp++;
        if (o_gnt_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_vld: got %b want 0", o_gnt_vld);
        end
        tick();
        i_nrst = 1'b1;
        i_req  = 4'b1111;
        tick();
        n_cmp++;
        if (o_gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL midreset_restart: got %b want 0001", o_gnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        i_weight = 16'h1111;
        i_req    = 4'b1000;
        i_beat   = 1'b0;
`ifdef WRR_ARBITER_TIMEOUT_EN
        for (int t = 0; t < 16; t++) begin
            tick();
            n_cmp++;
            if (o_gnt !== 4'b1000 || o_timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_hold[%0d]: got gnt=%b to=%b want gnt=1000 to=0", t, o_gnt, o_timeout);
            end
        end
        i_req = 4'b1001;
        tick();
        n_cmp++;
        if (o_gnt !== 4'b0000 || o_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_fire: got gnt=%b to=%b want gnt=0000 to=1", o_gnt, o_timeout);
        end
        tick();
        n_cmp++;
        if (o_gnt !== 4'b0001 || o_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_next: got gnt=%b to=%b want gnt=0001 to=0", o_gnt, o_timeout);
        end
`else
        for (int t = 0; t < 40; t++) begin
            tick();
            n_cmp++;
            if (o_gnt !== 4'b1000 || o_timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL nowatchdog_hold[%0d]: got gnt=%b to=%b want gnt=1000 to=0", t, o_gnt, o_timeout);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        i_weight = 16'($urandom);
        i_req    = 4'($urandom);
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) i_req = i_req ^ (4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) i_weight = 16'($urandom);
            i_beat = (t >= 300 && t < 420) ? 1'b0 : ($urandom_range(0, 1) == 1);
            tick();
            eg = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
            n_cmp++;
            if (o_gnt !== eg) begin
                n_bad++;
                $display("FAIL rand_gnt[%0d]: got %b want %b", t, o_gnt, eg);
            end
            n_cmp++;
            if (o_gnt_vld !== (m_own >= 0)) begin
                n_bad++;
                $display("FAIL rand_vld[%0d]: got %b want %b", t, o_gnt_vld, m_own >= 0);
            end
            n_cmp++;
            if (o_gnt_id !== 2'((m_own < 0) ? 0 : m_own)) begin
                n_bad++;
                $display("FAIL rand_id[%0d]: got %0d want %0d", t, o_gnt_id, (m_own < 0) ? 0 : m_own);
            end
            n_cmp++;
            if (o_timeout !== m_tout) begin
                n_bad++;
                $display("FAIL rand_timeout[%0d]: got %b want %b", t, o_timeout, m_tout);
            end
        end
    endtask

    initial begin
        i_nrst   = 1'b0;
        i_req    = 4'b0;
        i_weight = 16'h0;
        i_beat   = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_weighted_drop();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
